serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: x - y - bin over WIDTH cycles through one
// full-subtractor cell, with a start/busy/done handshake and registered flags.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Handshake: start is accepted on any edge where the block is not in RUN
    // (IDLE or DONE); busy is high exactly while bits are processed, and done
    // is a one-cycle pulse on which d/bout/ovf/zero are already valid.
    state_t           state, state_nxt;
    logic [WIDTH-1:0] sx, sy, res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             br, br_nxt, diff_bit, last_bit, accept;
    logic             x_msb, y_msb;

    assign diff_bit = sx[0] ^ sy[0] ^ br;
    assign br_nxt   = (~sx[0] & sy[0]) | (~sx[0] & br) | (sy[0] & br);
    assign res_nxt  = {diff_bit, res[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state != RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx    <= '0;
            sy    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            x_msb <= 1'b0;
            y_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (accept) begin
                sx    <= x;
                sy    <= y;
                br    <= bin;
                x_msb <= x[WIDTH-1];
                y_msb <= y[WIDTH-1];
                res   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                sx  <= sx >> 1;
                sy  <= sy >> 1;
                br  <= br_nxt;
                res <= res_nxt;
                cnt <= cnt + 1'b1;
                // Outputs move only here, so partial results never show.
                if (last_bit) begin
                    d    <= res_nxt;
                    bout <= br_nxt;
                    ovf  <= (x_msb != y_msb) && (res_nxt[WIDTH-1] != x_msb);
                    zero <= (res_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       busy4, done4, bout4, ovf4, zero4;
    logic [3:0] d4;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       busy8, done8, bout8, ovf8, zero8;
    logic [7:0] d8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4), .zero(zero4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    // Returns {d[15:0], bout, ovf, zero} from plain integer arithmetic.
    function automatic logic [18:0] ref_model(int w, int xv, int yv, int bv);
        int diff, dm, sxv, syv, s;
        logic bo, ov, z;
        diff = xv - yv - bv;
        dm   = diff & ((1 << w) - 1);
        bo   = (diff < 0);
        sxv  = (xv >= (1 << (w - 1))) ? xv - (1 << w) : xv;
        syv  = (yv >= (1 << (w - 1))) ? yv - (1 << w) : yv;
        s    = sxv - syv - bv;
        ov   = (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
        z    = (dm == 0);
        return {dm[15:0], bo, ov, z};
    endfunction

    // Launch one 4-bit op; scramble inputs during RUN; wait for done.
    // When check_hold is set, outputs must keep hold_exp until done.
    task automatic run4(input logic [3:0] xv, input logic [3:0] yv, input logic bv,
                        input logic check_hold, input logic [6:0] hold_exp,
                        output int lat, output int bcnt);
        @(negedge clk);
        x4 = xv; y4 = yv; bin4 = bv; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        x4 = 4'($urandom); y4 = 4'($urandom); bin4 = 1'($urandom);
        lat = 0; bcnt = 0;
        while (!done4 && lat < 40) begin
            if (busy4) bcnt++;
            if (check_hold) begin
                vectors++;
                if ({d4, bout4, ovf4, zero4} !== hold_exp) begin
                    miscompares++;
                    $display("FAIL hold4 got=%h want=%h", {d4, bout4, ovf4, zero4}, hold_exp);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!done4) begin
            vectors++; miscompares++;
            $display("FAIL timeout4 no done after %0d cycles, want 4", lat);
        end
    endtask

    task automatic run8(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                        input logic [10:0] hold_exp, output int lat);
        @(negedge clk);
        x8 = xv; y8 = yv; bin8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); bin8 = 1'($urandom);
        lat = 0;
        while (!done8 && lat < 40) begin
            vectors++;
            if ({d8, bout8, ovf8, zero8} !== hold_exp) begin
                miscompares++;
                $display("FAIL hold8 got=%h want=%h", {d8, bout8, ovf8, zero8}, hold_exp);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!done8) begin
            vectors++; miscompares++;
            $display("FAIL timeout8 no done after %0d cycles, want 8", lat);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({busy4, done4, d4, bout4, ovf4, zero4} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset4 got=%h want=0", {busy4, done4, d4, bout4, ovf4, zero4});
        end
        vectors++;
        if ({busy8, done8, d8, bout8, ovf8, zero8} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset8 got=%h want=0", {busy8, done8, d8, bout8, ovf8, zero8});
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        run4(4'd7, 4'd2, 1'b0, 1'b0, 7'd0, lat, bc);
        vectors++;
        if (d4 !== 4'd5) begin
            miscompares++; $display("FAIL pre_reset_d got=%0d want=5", d4);
        end
        @(negedge clk);
        x4 = 4'd7; y4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy4, done4, d4, bout4, ovf4, zero4} !== 9'd0) begin
            miscompares++;
            $display("FAIL mid_run_reset got=%h want=0", {busy4, done4, d4, bout4, ovf4, zero4});
        end
        #2 rst_n = 1'b1;
        run4(4'd7, 4'd2, 1'b0, 1'b0, 7'd0, lat, bc);
        vectors++;
        if (d4 !== 4'd5) begin
            miscompares++; $display("FAIL post_reset_d got=%0d want=5", d4);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        run4(4'd7, 4'd2, 1'b0, 1'b1, {4'd5, 3'b000}, lat, bc);
        vectors++;
        if (lat !== 4) begin
            miscompares++; $display("FAIL latency got=%0d want=4", lat);
        end
        vectors++;
        if (bc !== 4) begin
            miscompares++; $display("FAIL busy_cycles got=%0d want=4", bc);
        end
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd5, 3'b000}) begin
            miscompares++; $display("FAIL sub_7_2 got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd5, 3'b000});
        end
        @(posedge clk); #1;
        vectors++;
        if ({done4, busy4, d4} !== {2'b00, 4'd5}) begin
            miscompares++; $display("FAIL done_pulse got=%h want=%h", {done4, busy4, d4}, {2'b00, 4'd5});
        end
    endtask

    task automatic test_borrow_ovf();
        int lat, bc;
        run4(4'd3, 4'd5, 1'b0, 1'b1, {4'd5, 3'b000}, lat, bc);
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd14, 3'b100}) begin
            miscompares++; $display("FAIL sub_3_5 got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd14, 3'b100});
        end
        run4(4'd8, 4'd1, 1'b0, 1'b1, {4'd14, 3'b100}, lat, bc);
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd7, 3'b010}) begin
            miscompares++; $display("FAIL sub_8_1 got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd7, 3'b010});
        end
    endtask

    task automatic test_zero_bin();
        int lat, bc;
        run4(4'd5, 4'd4, 1'b1, 1'b1, {4'd7, 3'b010}, lat, bc);
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd0, 3'b001}) begin
            miscompares++; $display("FAIL sub_5_4_b got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd0, 3'b001});
        end
        run4(4'd0, 4'd0, 1'b1, 1'b1, {4'd0, 3'b001}, lat, bc);
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd15, 3'b100}) begin
            miscompares++; $display("FAIL sub_0_0_b got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd15, 3'b100});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        x4 = 4'd15; y4 = 4'd15; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        x4 = 4'd9; y4 = 4'd3;
        n = 0;
        while (!done4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++; $display("FAIL b2b_first_latency got=%0d want=4", n);
        end
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd0, 3'b001}) begin
            miscompares++; $display("FAIL b2b_first got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd0, 3'b001});
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        vectors++;
        if ({done4, busy4} !== 2'b01) begin
            miscompares++; $display("FAIL b2b_restart got=%b want=01", {done4, busy4});
        end
        n = 1;
        while (!done4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n !== 5) begin
            miscompares++; $display("FAIL b2b_spacing got=%0d want=5", n);
        end
        vectors++;
        if ({d4, bout4, ovf4, zero4} !== {4'd6, 3'b010}) begin
            miscompares++; $display("FAIL b2b_second got=%h want=%h", {d4, bout4, ovf4, zero4}, {4'd6, 3'b010});
        end
    endtask

    task automatic test_random4();
        int lat, bc;
        logic [18:0] r;
        logic [6:0]  prev;
        logic [3:0]  xv, yv;
        logic        bv;
        prev = {d4, bout4, ovf4, zero4};
        for (int i = 0; i < 500; i++) begin
            xv = 4'($urandom_range(0, 15));
            yv = 4'($urandom_range(0, 15));
            bv = 1'($urandom_range(0, 1));
            r  = ref_model(4, int'(xv), int'(yv), int'(bv));
            run4(xv, yv, bv, 1'b1, prev, lat, bc);
            vectors++;
            if ({d4, bout4, ovf4, zero4} !== r[6:0]) begin
                miscompares++;
                $display("FAIL rand4 %0d-%0d-%0d got=%h want=%h", xv, yv, bv, {d4, bout4, ovf4, zero4}, r[6:0]);
            end
            prev = r[6:0];
        end
    endtask

    task automatic test_random8();
        int lat;
        logic [18:0] r;
        logic [10:0] prev;
        logic [7:0]  xv, yv;
        logic        bv;
        prev = {d8, bout8, ovf8, zero8};
        for (int i = 0; i < 500; i++) begin
            xv = 8'($urandom_range(0, 255));
            yv = 8'($urandom_range(0, 255));
            bv = 1'($urandom_range(0, 1));
            r  = ref_model(8, int'(xv), int'(yv), int'(bv));
            run8(xv, yv, bv, prev, lat);
            vectors++;
            if (lat !== 8) begin
                miscompares++; $display("FAIL latency8 got=%0d want=8", lat);
            end
            vectors++;
            if ({d8, bout8, ovf8, zero8} !== r[10:0]) begin
                miscompares++;
                $display("FAIL rand8 %0d-%0d-%0d got=%h want=%h", xv, yv, bv, {d8, bout8, ovf8, zero8}, r[10:0]);
            end
            prev = r[10:0];
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_borrow_ovf();
        test_zero_bin();
        test_back_to_back();
        test_random4();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
